// File: rtl/int_pkg.sv
// Shared constants and types for the interrupt controller: bus addresses,
// interrupt bit indices and vector generation.
package int_pkg;

    localparam int NUM_INT = 5;
    localparam int IDX_W   = $clog2(NUM_INT);

    localparam logic [15:0] ADDR_IF = 16'hFF0F;
    localparam logic [15:0] ADDR_IE = 16'hFFFF;

    localparam int INT_VBLANK = 0;
    localparam int INT_STAT   = 1;
    localparam int INT_TIMER  = 2;
    localparam int INT_SERIAL = 3;
    localparam int INT_JOYPAD = 4;

    localparam logic [7:0] VEC_BASE = 8'h40;

    typedef logic [NUM_INT-1:0] int_vec_t;

    // Vectors are spaced 8 bytes apart starting at VEC_BASE.
    function automatic logic [7:0] int_vector(input logic [IDX_W-1:0] k);
        return VEC_BASE + (8'(k) << 3);
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-set-bit priority encoder; bit 0 has the highest priority.
module int_prio_enc
    import int_pkg::*;
(
    input  logic [NUM_INT-1:0] p,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (p[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign valid = |p;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: captures peripheral request handshakes into IF, holds
// IE, and presents the highest-priority enabled pending interrupt to the CPU.
module int_ctrl
    import int_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        a,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    input  logic               rd,
    input  logic               wr,
    input  logic [NUM_INT-1:0] int_req,
    output logic [NUM_INT-1:0] int_ack,
    output logic               cpu_int_pending,
    output logic [7:0]         cpu_int_vector,
    input  logic               cpu_int_dispatch
);

    int_vec_t         if_r;
    int_vec_t         ack_r;
    logic [7:0]       ie_r;
    int_vec_t         capture;
    int_vec_t         pend;
    int_vec_t         clr;
    logic             pend_vld;
    logic [IDX_W-1:0] pend_idx;
    logic             wr_if;
    logic             wr_ie;
    logic             unused_rd;

    // Reads are side-effect free, so the strobe carries no information here.
    assign unused_rd = &{1'b0, rd};

    assign wr_if   = wr && (a == ADDR_IF);
    assign wr_ie   = wr && (a == ADDR_IE);
    assign capture = int_req & ~ack_r;
    assign pend    = if_r & ie_r[NUM_INT-1:0];

    int_prio_enc u_prio (
        .p     (pend),
        .valid (pend_vld),
        .idx   (pend_idx)
    );

    assign clr = (cpu_int_dispatch && pend_vld) ? (int_vec_t'(1) << pend_idx) : '0;

    // Capture is ORed in last so a new request is never lost to a write or dispatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_r  <= '0;
            ack_r <= '0;
            ie_r  <= 8'h00;
        end else begin
            ack_r <= int_req;
            if (wr_if) begin
                if_r <= din[NUM_INT-1:0] | capture;
            end else begin
                if_r <= (if_r & ~clr) | capture;
            end
            if (wr_ie) begin
                ie_r <= din;
            end
        end
    end

    always_comb begin
        dout = 8'hFF;
        if (a == ADDR_IF) begin
            dout = {{(8 - NUM_INT){1'b1}}, if_r};
        end else if (a == ADDR_IE) begin
            dout = ie_r;
        end
    end

    assign int_ack          = ack_r;
    assign cpu_int_pending  = pend_vld;
    assign cpu_int_vector   = pend_vld ? int_vector(pend_idx) : 8'h00;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_int_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        rd;
    logic        wr;
    logic [4:0]  int_req;
    logic [4:0]  int_ack;
    logic        cpu_int_pending;
    logic [7:0]  cpu_int_vector;
    logic        cpu_int_dispatch;

    int checks;
    int errors;

    int_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .a                (a),
        .din              (din),
        .dout             (dout),
        .rd               (rd),
        .wr               (wr),
        .int_req          (int_req),
        .int_ack          (int_ack),
        .cpu_int_pending  (cpu_int_pending),
        .cpu_int_vector   (cpu_int_vector),
        .cpu_int_dispatch (cpu_int_dispatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  din;
        logic        wr;
        logic [4:0]  req;
        logic        disp;
        logic [15:0] rd_a;
        logic [7:0]  e_dout;
        logic [4:0]  e_ack;
        logic        e_pend;
        logic [7:0]  e_vec;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic [15:0] va, input logic [7:0] vdin, input logic vwr,
                                input logic [4:0] vreq, input logic vdisp, input logic [15:0] vrd,
                                input logic [7:0] edout, input logic [4:0] eack, input logic epend,
                                input logic [7:0] evec);
        vec_t v;
        v.a = va; v.din = vdin; v.wr = vwr; v.req = vreq; v.disp = vdisp;
        v.rd_a = vrd; v.e_dout = edout; v.e_ack = eack; v.e_pend = epend; v.e_vec = evec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a = 16'h0000; din = 8'h00; wr = 1'b0; rd = 1'b0; cpu_int_dispatch = 1'b0;
    endtask

    // Behavioural reference model state.
    logic [4:0] m_if;
    logic [7:0] m_ie;
    logic [4:0] m_req_seen;

    function automatic int lowest(input logic [4:0] p);
        for (int i = 0; i < 5; i++) begin
            if (p[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_vec();
        int k;
        k = lowest(m_if & m_ie[4:0]);
        return (k < 0) ? 8'h00 : 8'(64 + 8 * k);
    endfunction

    function automatic logic [7:0] model_dout(input logic [15:0] addr);
        if (addr == 16'hFF0F) return {3'b111, m_if};
        if (addr == 16'hFFFF) return m_ie;
        return 8'hFF;
    endfunction

    task automatic model_edge();
        logic [4:0] nif;
        int k;
        k = lowest(m_if & m_ie[4:0]);
        if (wr && a == 16'hFF0F) begin
            nif = din[4:0];
        end else begin
            nif = m_if;
            if (cpu_int_dispatch && k >= 0) nif[k] = 1'b0;
        end
        for (int n = 0; n < 5; n++) begin
            if (int_req[n] && !m_req_seen[n]) nif[n] = 1'b1;
        end
        if (wr && a == 16'hFFFF) m_ie = din;
        m_if = nif;
        m_req_seen = int_req;
    endtask

    initial begin
        logic [15:0] addrs[4];
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        int_req = 5'b0;
        idle_inputs();

        tbl[0]  = mk(16'h0000, 8'h00, 0, 5'h08, 0, 16'hFF0F, 8'hE8, 5'h08, 0, 8'h00);
        tbl[1]  = mk(16'h0000, 8'h00, 0, 5'h08, 0, 16'hFF0F, 8'hE8, 5'h08, 0, 8'h00);
        tbl[2]  = mk(16'h0000, 8'h00, 0, 5'h00, 0, 16'hFF0F, 8'hE8, 5'h00, 0, 8'h00);
        tbl[3]  = mk(16'hFFFF, 8'h1F, 1, 5'h00, 0, 16'hFF0F, 8'hE8, 5'h00, 1, 8'h58);
        tbl[4]  = mk(16'hFF0F, 8'h00, 1, 5'h00, 0, 16'hFF0F, 8'hE0, 5'h00, 0, 8'h00);
        tbl[5]  = mk(16'h0000, 8'h00, 0, 5'h0C, 0, 16'hFF0F, 8'hEC, 5'h0C, 1, 8'h50);
        tbl[6]  = mk(16'h0000, 8'h00, 0, 5'h00, 1, 16'hFF0F, 8'hE8, 5'h00, 1, 8'h58);
        tbl[7]  = mk(16'h0000, 8'h00, 0, 5'h00, 1, 16'hFF0F, 8'hE0, 5'h00, 0, 8'h00);
        tbl[8]  = mk(16'h0000, 8'h00, 0, 5'h00, 1, 16'hFF0F, 8'hE0, 5'h00, 0, 8'h00);
        tbl[9]  = mk(16'hFFFF, 8'h08, 1, 5'h00, 0, 16'hFFFF, 8'h08, 5'h00, 0, 8'h00);
        tbl[10] = mk(16'hFF0F, 8'h05, 1, 5'h00, 0, 16'hFF0F, 8'hE5, 5'h00, 0, 8'h00);
        tbl[11] = mk(16'h0000, 8'h00, 0, 5'h00, 0, 16'hFFFF, 8'h08, 5'h00, 0, 8'h00);
        tbl[12] = mk(16'h0000, 8'h00, 0, 5'h00, 0, 16'hFF10, 8'hFF, 5'h00, 0, 8'h00);
        tbl[13] = mk(16'hFFFF, 8'h1F, 1, 5'h00, 0, 16'hFFFF, 8'h1F, 5'h00, 1, 8'h40);
        tbl[14] = mk(16'hFF0F, 8'h00, 1, 5'h01, 0, 16'hFF0F, 8'hE1, 5'h01, 1, 8'h40);
        tbl[15] = mk(16'h0000, 8'h00, 0, 5'h00, 0, 16'hFF0F, 8'hE1, 5'h00, 1, 8'h40);
        tbl[16] = mk(16'h0000, 8'h00, 0, 5'h01, 1, 16'hFF0F, 8'hE1, 5'h01, 1, 8'h40);
        tbl[17] = mk(16'h0000, 8'h00, 0, 5'h01, 1, 16'hFF0F, 8'hE0, 5'h01, 0, 8'h00);
        tbl[18] = mk(16'h0000, 8'h00, 0, 5'h00, 0, 16'hFF0F, 8'hE0, 5'h00, 0, 8'h00);
        tbl[19] = mk(16'hFF0F, 8'h06, 1, 5'h00, 0, 16'hFF0F, 8'hE6, 5'h00, 1, 8'h48);
        tbl[20] = mk(16'hFF0F, 8'h06, 1, 5'h00, 1, 16'hFF0F, 8'hE6, 5'h00, 1, 8'h48);

        #12;
        // Reset state
        a = 16'hFF0F; #1;
        chk("reset_if", dout, 8'hE0);
        a = 16'hFFFF; #1;
        chk("reset_ie", dout, 8'h00);
        chk("reset_ack", {3'b0, int_ack}, 8'h00);
        chk("reset_pend", {7'b0, cpu_int_pending}, 8'h00);
        chk("reset_vec", cpu_int_vector, 8'h00);
        idle_inputs();
        #2 rst_n = 1'b1;
        step();

        // Directed vector table
        for (int i = 0; i < 21; i++) begin
            a = tbl[i].a; din = tbl[i].din; wr = tbl[i].wr;
            int_req = tbl[i].req; cpu_int_dispatch = tbl[i].disp;
            step();
            wr = 1'b0; cpu_int_dispatch = 1'b0; a = tbl[i].rd_a;
            #1;
            chk($sformatf("tbl%0d_dout", i), dout, tbl[i].e_dout);
            chk($sformatf("tbl%0d_ack", i), {3'b0, int_ack}, {3'b0, tbl[i].e_ack});
            chk($sformatf("tbl%0d_pend", i), {7'b0, cpu_int_pending}, {7'b0, tbl[i].e_pend});
            chk($sformatf("tbl%0d_vec", i), cpu_int_vector, tbl[i].e_vec);
        end

        // A held request sets IF only once
        a = 16'hFF0F; din = 8'h00; wr = 1'b1; int_req = 5'h08;
        step();
        wr = 1'b0; a = 16'hFF0F; #1;
        chk("hold_first_set", dout, 8'hE8);
        wr = 1'b1;
        step();
        wr = 1'b0;
        for (int i = 0; i < 9; i++) step();
        a = 16'hFF0F; #1;
        chk("hold_no_reset", dout, 8'hE0);
        chk("hold_ack", {3'b0, int_ack}, 8'h08);

        // Reset mid-handshake, between edges
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_if", dout, 8'hE0);
        chk("async_rst_ack", {3'b0, int_ack}, 8'h00);
        a = 16'hFFFF; #1;
        chk("async_rst_ie", dout, 8'h00);
        chk("async_rst_pend", {7'b0, cpu_int_pending}, 8'h00);
        #1 rst_n = 1'b1;
        step();
        a = 16'hFF0F; #1;
        chk("post_rst_if", dout, 8'hE8);
        chk("post_rst_ack", {3'b0, int_ack}, 8'h08);

        // Randomized traffic against the model
        int_req = 5'h00; idle_inputs();
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        m_if = 5'h00; m_ie = 8'h00; m_req_seen = 5'h00;
        addrs[0] = 16'hFF0F; addrs[1] = 16'hFFFF; addrs[2] = 16'hFF10; addrs[3] = 16'h0000;
        step();
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 5; n++) begin
                if ($urandom_range(3) == 0) int_req[n] = ~int_req[n];
            end
            addrs[3] = 16'($urandom);
            a = addrs[$urandom_range(3)];
            din = 8'($urandom);
            wr = ($urandom_range(5) == 0);
            cpu_int_dispatch = ($urandom_range(2) == 0);
            #1;
            chk("rnd_dout", dout, model_dout(a));
            chk("rnd_ack", {3'b0, int_ack}, {3'b0, m_req_seen});
            chk("rnd_pend", {7'b0, cpu_int_pending}, {7'b0, (m_if & m_ie[4:0]) != 5'h00});
            chk("rnd_vec", cpu_int_vector, model_vec());
            model_edge();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
